// File: rtl/multi_dice_roller.sv
// rtl/multi_dice_roller.sv - N-die odometer dice roller with per-die lock, settle phase and registered sum
module multi_dice_roller #(
    parameter int N_DICE = 2,
    parameter int FACES  = 6,
    parameter int SETTLE = 4,
    localparam int W  = $clog2(FACES + 1),
    localparam int SW = $clog2(N_DICE * FACES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                button,
    input  logic [N_DICE-1:0]   lock,
    output logic [N_DICE*W-1:0] throw,
    output logic [SW-1:0]       total,
    output logic                rolling,
    output logic                result_valid
);

    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {IDLE, ROLLING, SETTLING, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [N_DICE*W-1:0] next_throw;
    logic [SW-1:0]       cur_sum;
    logic [SW-1:0]       next_sum;
    logic                carry;
    logic                adv;

    assign adv = (((state == IDLE) || (state == ROLLING)) && button) || (state == SETTLING);

    // Odometer step: locked dice are transparent to the carry; 0->1 never carries.
    always_comb begin
        next_throw = throw;
        carry      = 1'b1;
        cur_sum    = '0;
        next_sum   = '0;
        for (int k = 0; k < N_DICE; k++) begin
            if (!lock[k]) begin
                if (carry) begin
                    if ((throw[k*W +: W] == W'(0)) || (throw[k*W +: W] == W'(FACES)))
                        next_throw[k*W +: W] = W'(1);
                    else
                        next_throw[k*W +: W] = throw[k*W +: W] + W'(1);
                end
                carry = carry && (throw[k*W +: W] == W'(FACES));
            end
        end
        for (int k = 0; k < N_DICE; k++) begin
            cur_sum  = cur_sum + SW'(throw[k*W +: W]);
            next_sum = next_sum + SW'(next_throw[k*W +: W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            throw        <= '0;
            total        <= '0;
            rolling      <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            if (adv)
                throw <= next_throw;
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (button) begin
                        state   <= ROLLING;
                        rolling <= 1'b1;
                    end
                end
                ROLLING: begin
                    if (!button) begin
                        if (SETTLE > 0) begin
                            state <= SETTLING;
                            cnt   <= CW'(SETTLE);
                        end else begin
                            state        <= DONE;
                            total        <= cur_sum;
                            rolling      <= 1'b0;
                            result_valid <= 1'b1;
                        end
                    end
                end
                SETTLING: begin
                    cnt <= cnt - 1'b1;
                    if (button) begin
                        state <= ROLLING;
                    end else if (cnt == CW'(1)) begin
                        state        <= DONE;
                        total        <= next_sum;
                        rolling      <= 1'b0;
                        result_valid <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_dice_roller.sv
// tb/tb_multi_dice_roller.sv - self-checking bench for multi_dice_roller
module tb_multi_dice_roller;

    localparam int FACES = 6;

    logic       clk = 0;
    logic       rst;
    logic       button;
    logic [1:0] lock;
    logic [5:0] throw_a;
    logic [3:0] total_a;
    logic       rolling_a;
    logic       rv_a;

    logic       button_b;
    logic [1:0] lock_b;
    logic [5:0] throw_b;
    logic [3:0] total_b;
    logic       rolling_b;
    logic       rv_b;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    multi_dice_roller #(.N_DICE(2), .FACES(6), .SETTLE(4)) dut_a (
        .clk(clk), .rst(rst), .button(button), .lock(lock),
        .throw(throw_a), .total(total_a), .rolling(rolling_a), .result_valid(rv_a)
    );

    multi_dice_roller #(.N_DICE(2), .FACES(6), .SETTLE(0)) dut_b (
        .clk(clk), .rst(rst), .button(button_b), .lock(lock_b),
        .throw(throw_b), .total(total_b), .rolling(rolling_b), .result_valid(rv_b)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int die(input logic [5:0] t, input int k);
        return int'(t[k*3 +: 3]);
    endfunction

    // Reference model: phase 0 idle, 1 rolling, 2 settling, 3 done.
    int m_face[2];
    int m_phase, m_left, m_total;

    function automatic int face_sum();
        return m_face[0] + m_face[1];
    endfunction

    task automatic odometer(input logic [1:0] lk);
        int  old[2];
        bit  c;
        old = m_face;
        c   = 1;
        for (int k = 0; k < 2; k++) begin
            if (!lk[k]) begin
                if (c) m_face[k] = (old[k] == 0 || old[k] == FACES) ? 1 : old[k] + 1;
                c = c && (old[k] == FACES);
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_face  = '{0, 0};
            m_phase = 0;
            m_left  = 0;
            m_total = 0;
        end else begin
            if (((m_phase == 0 || m_phase == 1) && button) || m_phase == 2)
                odometer(lock);
            case (m_phase)
                0: if (button) m_phase = 1;
                1: if (!button) begin m_phase = 2; m_left = 4; end
                2: begin
                    m_left = m_left - 1;
                    if (button) m_phase = 1;
                    else if (m_left == 0) begin m_phase = 3; m_total = face_sum(); end
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("model die0", die(throw_a, 0), m_face[0]);
        chk("model die1", die(throw_a, 1), m_face[1]);
        chk("model total", int'(total_a), m_total);
        chk("model rolling", int'(rolling_a), int'(m_phase == 1 || m_phase == 2));
        chk("model result_valid", int'(rv_a), int'(m_phase == 3));
        if (rv_a) pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_dice(input string n, input int d0, input int d1);
        chk({n, " die0"}, die(throw_a, 0), d0);
        chk({n, " die1"}, die(throw_a, 1), d1);
    endtask

    initial begin
        rst = 1; button = 0; lock = 2'b00; button_b = 0; lock_b = 2'b00;
        tick();
        expect_dice("reset", 0, 0);
        chk("reset total", int'(total_a), 0);
        chk("reset rolling", int'(rolling_a), 0);
        chk("reset rv", int'(rv_a), 0);
        tick();
        rst = 0;

        // Basic roll: three presses, release, four settle advances
        button = 1;
        tick(); expect_dice("roll e1", 1, 0); chk("roll e1 rolling", int'(rolling_a), 1);
        tick(); expect_dice("roll e2", 2, 0);
        tick(); expect_dice("roll e3", 3, 0);
        button = 0;
        tick(); expect_dice("release", 3, 0);
        tick(); expect_dice("settle1", 4, 0);
        tick(); expect_dice("settle2", 5, 0);
        tick(); expect_dice("settle3", 6, 0); chk("settle3 rv", int'(rv_a), 0);
        tick(); expect_dice("settle4", 1, 1);
        chk("done rv", int'(rv_a), 1); chk("done total", int'(total_a), 2);
        tick(); chk("idle rv", int'(rv_a), 0); chk("idle rolling", int'(rolling_a), 0);
        chk("idle total", int'(total_a), 2); expect_dice("idle hold", 1, 1);

        // Lock steering: die0 locked passes carry, so die1 steps
        button = 1; lock = 2'b01;
        tick(); expect_dice("lock01", 1, 2);
        lock = 2'b10;
        tick(); tick(); expect_dice("lock10", 3, 2);
        lock = 2'b01;
        tick(); expect_dice("lock e1", 3, 3);
        tick(); expect_dice("lock e2", 3, 4);
        tick(); expect_dice("lock e3", 3, 5);
        lock = 2'b00; button = 0;
        repeat (5) tick();
        chk("lock done rv", int'(rv_a), 1); chk("lock done total", int'(total_a), 7);
        expect_dice("lock done", 1, 6);
        tick();

        // Double wrap: 6/6 -> 1/1 in one advance, top carry dropped
        button = 1; lock = 2'b10;
        repeat (5) tick();
        expect_dice("pre wrap", 6, 6);
        lock = 2'b00;
        tick(); expect_dice("wrap", 1, 1);
        button = 0;
        repeat (5) tick();
        chk("wrap total", int'(total_a), 6); chk("wrap rv", int'(rv_a), 1);
        tick();

        // Re-press on second settle edge aborts the settle
        pulses = 0;
        button = 1;
        tick(); expect_dice("rp roll", 6, 1);
        button = 0;
        tick(); tick(); expect_dice("rp s1", 1, 2);
        button = 1;
        tick(); expect_dice("rp s2", 2, 2);
        chk("rp rolling", int'(rolling_a), 1); chk("rp rv", int'(rv_a), 0);
        chk("rp total", int'(total_a), 6);
        button = 0;
        repeat (5) tick();
        chk("rp done rv", int'(rv_a), 1); chk("rp done total", int'(total_a), 8);
        expect_dice("rp done", 6, 2);
        tick(); tick();
        chk("rp pulses", pulses, 1);

        // Asynchronous reset mid-roll, between edges
        button = 1;
        tick(); tick(); expect_dice("pre rst", 2, 3);
        #2 rst = 1;
        #1;
        expect_dice("async rst", 0, 0);
        chk("async rst total", int'(total_a), 0);
        chk("async rst rolling", int'(rolling_a), 0);
        chk("async rst rv", int'(rv_a), 0);
        button = 0;
        tick();
        rst = 0;
        tick();

        // SETTLE=0 instance: release edge goes straight to DONE
        button_b = 1;
        tick(); tick();
        chk("s0 die0", die(throw_b, 0), 2); chk("s0 rolling", int'(rolling_b), 1);
        button_b = 0;
        tick();
        chk("s0 rv", int'(rv_b), 1); chk("s0 total", int'(total_b), 2);
        chk("s0 rolling done", int'(rolling_b), 0); chk("s0 die0 held", die(throw_b, 0), 2);
        tick();
        chk("s0 rv drop", int'(rv_b), 0); chk("s0 total hold", int'(total_b), 2);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
